// File: rtl/router_input_buffer.sv
// -----------------------------------------------------------------------------
// router_input_buffer
//
// Receive end of a credit-based router link. Incoming flits are stored in a
// FIFO whose depth matches the upstream credit count. The head flit is shown
// to the output-port arbiters. Each shown flit is marked as header and/or tail
// using the payload-length field of its packet's header flit. Every popped flit
// returns one credit upstream as a one-cycle pulse on yummy_out.
//
// Optional feature macro: ROUTER_INPUT_OVERFLOW_CHECK_EN
//   defined   : overflow_err is a sticky flag. It is set when a flit arrives
//               while the FIFO is full and nothing is popped in that cycle.
//   undefined : overflow_err is tied to 0 and no detection logic is built.
//   The dropped flit is handled the same way in both builds.
//
// Ports
//   clk           in   1      clock, rising-edge active
//   reset         in   1      synchronous reset, active-low
//   valid_in      in   1      data_in carries a flit this cycle
//   data_in       in   WIDTH  incoming flit
//   thanks_in     in   1      pop the head flit (ignored while empty)
//   data_out      out  WIDTH  head flit of the FIFO (combinational read)
//   valid_out     out  1      FIFO not empty
//   head_out      out  1      data_out is a header flit
//   tail_out      out  1      data_out is the last flit of its packet
//   yummy_out     out  1      one-cycle credit return per pop
//   overflow_err  out  1      sticky credit-violation flag
// -----------------------------------------------------------------------------

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module router_input_buffer #(
  parameter int WIDTH       = `DATA_WIDTH,
  parameter int BUFFER_SIZE = 32,
  parameter int BUFFER_BITS = 6,
  parameter int LEN_LSB     = 2 * (2 * `XY_WIDTH + `CHIP_ID_WIDTH),
  parameter int LEN_BITS    = `PAYLOAD_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             thanks_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             head_out,
  output logic             tail_out,
  output logic             yummy_out,
  output logic             overflow_err
);

  // A depth of 1 still needs a 1-bit pointer.
  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam logic [PTR_W-1:0]       PTR_LAST  = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [BUFFER_BITS-1:0] CNT_FULL  = BUFFER_BITS'(BUFFER_SIZE);

  typedef enum logic {
    PKT_HEAD = 1'b0,
    PKT_BODY = 1'b1
  } pkt_state_t;

  // ---------------------------------------------------------------------------
  // Storage and occupancy
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       mem [BUFFER_SIZE];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [BUFFER_BITS-1:0] count_reg;
  logic                   yummy_reg;

  logic full;
  logic push;
  logic pop;

  assign full      = (count_reg == CNT_FULL);
  assign valid_out = (count_reg != '0);
  assign pop       = thanks_in & valid_out;
  // At full, a push is still accepted when the head leaves in the same cycle.
  // The freed slot is the one wr_ptr already points at, so order is preserved.
  assign push      = valid_in & (~full | pop);

  assign data_out  = mem[rd_ptr_reg];
  assign yummy_out = yummy_reg;

  // Storage has no reset. Its contents are only observed while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      yummy_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      yummy_reg <= pop;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet framing, tracked on the dequeue side
  // ---------------------------------------------------------------------------
  pkt_state_t          state_reg;
  pkt_state_t          state_next;
  logic [LEN_BITS-1:0] rem_reg;
  logic [LEN_BITS-1:0] rem_next;
  logic [LEN_BITS-1:0] head_len;

  assign head_len = data_out[LEN_LSB+LEN_BITS-1:LEN_LSB];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= PKT_HEAD;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // rem counts the body flits still to come, including the one at the head.
  // BODY is only entered with rem >= 1, so the decrement cannot wrap.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    head_out   = 1'b0;
    tail_out   = 1'b0;
    case (state_reg)
      PKT_HEAD: begin
        head_out = valid_out;
        tail_out = valid_out & (head_len == '0);
        if (pop && (head_len != '0)) begin
          rem_next   = head_len;
          state_next = PKT_BODY;
        end
      end
      PKT_BODY: begin
        tail_out = valid_out & (rem_reg == LEN_BITS'(1));
        if (pop) begin
          rem_next = rem_reg - 1'b1;
          if (rem_reg == LEN_BITS'(1)) begin
            state_next = PKT_HEAD;
          end
        end
      end
      default: begin
        state_next = PKT_HEAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit-violation detection
  // ---------------------------------------------------------------------------
`ifdef ROUTER_INPUT_OVERFLOW_CHECK_EN
  logic overflow_reg;
  logic overflow_event;

  // The upstream sent a flit without holding a credit. The flit is dropped
  // by the push qualification above.
  assign overflow_event = valid_in & full & ~pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (overflow_event) begin
      overflow_reg <= 1'b1;
    end
  end

  assign overflow_err = overflow_reg;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
module tb_router_input_buffer;

  localparam int W = 64;

`ifdef ROUTER_INPUT_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [W-1:0] data_in;
  logic         thanks_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         head_out;
  logic         tail_out;
  logic         yummy_out;
  logic         overflow_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  router_input_buffer #(
    .WIDTH(W), .BUFFER_SIZE(4), .BUFFER_BITS(3), .LEN_LSB(48), .LEN_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .thanks_in(thanks_in), .data_out(data_out), .valid_out(valid_out),
    .head_out(head_out), .tail_out(tail_out), .yummy_out(yummy_out),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic         rst_n;
    logic         vi;
    logic [W-1:0] di;
    logic         th;
    logic         e_valid;
    logic         e_head;
    logic         e_tail;
    logic         e_yummy;
    logic         chk_data;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge, then settle; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic t);
    reset = r; valid_in = v; data_in = d; thanks_in = t;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] d,
                              input logic t, input logic ev, input logic eh,
                              input logic et, input logic ey, input logic cd,
                              input logic [W-1:0] ed);
    vec_t x;
    x.rst_n = r; x.vi = v; x.di = d; x.th = t; x.e_valid = ev; x.e_head = eh;
    x.e_tail = et; x.e_yummy = ey; x.chk_data = cd; x.e_data = ed;
    return x;
  endfunction

  localparam logic [W-1:0] HDR2 = 64'h0002_0000_0000_00C1;  // len=2
  localparam logic [W-1:0] HDR3 = 64'h0003_0000_0000_0005;  // len=3

  initial begin
    drive(1'b0, 1'b1, 64'h77, 1'b0);

    //             rst vi  data   th   v    h    t    y    cd   data
    vecs[0]  = mk(0, 1, 64'h77, 0,  0, 0, 0, 0, 0, 64'h0);   // reset with valid_in
    vecs[1]  = mk(0, 1, 64'h77, 0,  0, 0, 0, 0, 0, 64'h0);
    vecs[2]  = mk(1, 0, 64'h0,  0,  0, 0, 0, 0, 0, 64'h0);   // empty after release
    vecs[3]  = mk(1, 1, 64'hA5, 0,  1, 1, 1, 0, 1, 64'hA5);  // single-flit packet
    vecs[4]  = mk(1, 0, 64'h0,  1,  0, 0, 0, 1, 0, 64'h0);   // pop -> credit
    vecs[5]  = mk(1, 0, 64'h0,  0,  0, 0, 0, 0, 0, 64'h0);   // single pulse
    vecs[6]  = mk(1, 1, HDR2,   1,  1, 1, 0, 0, 1, HDR2);    // thanks while empty: no pop
    vecs[7]  = mk(1, 1, 64'h1,  1,  1, 0, 0, 1, 1, 64'h1);
    vecs[8]  = mk(1, 1, 64'h2,  1,  1, 0, 1, 1, 1, 64'h2);
    vecs[9]  = mk(1, 0, 64'h0,  1,  0, 0, 0, 1, 0, 64'h0);   // third pulse
    vecs[10] = mk(1, 0, 64'h0,  0,  0, 0, 0, 0, 0, 64'h0);
    vecs[11] = mk(1, 1, 64'h33, 0,  1, 1, 1, 0, 1, 64'h33);  // back in HEAD
    vecs[12] = mk(1, 0, 64'h0,  1,  0, 0, 0, 1, 0, 64'h0);
    vecs[13] = mk(1, 0, 64'h0,  1,  0, 0, 0, 0, 0, 64'h0);   // thanks on empty

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst_n, vecs[i].vi, vecs[i].di, vecs[i].th);
      step();
      chk($sformatf("vec%0d valid_out", i), 64'(valid_out), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d head_out", i),  64'(head_out),  64'(vecs[i].e_head));
      chk($sformatf("vec%0d tail_out", i),  64'(tail_out),  64'(vecs[i].e_tail));
      chk($sformatf("vec%0d yummy_out", i), 64'(yummy_out), 64'(vecs[i].e_yummy));
      chk($sformatf("vec%0d overflow", i),  64'(overflow_err), 64'(0));
      if (vecs[i].chk_data) chk($sformatf("vec%0d data_out", i), data_out, vecs[i].e_data);
    end

    // Overflow: five pushes into a four-deep FIFO, then drain.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 64'h10 + 64'(i), 1'b0);
      step();
      chk($sformatf("ovf push%0d overflow", i), 64'(overflow_err),
          64'((i == 4) ? OVF_EXP : 1'b0));
    end
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    step();
    chk("ovf sticky", 64'(overflow_err), 64'(OVF_EXP));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf drain%0d valid", i), 64'(valid_out), 64'(1));
      chk($sformatf("ovf drain%0d data", i), data_out, 64'h10 + 64'(i));
      drive(1'b1, 1'b0, 64'h0, 1'b1);
      step();
    end
    chk("ovf drained empty", 64'(valid_out), 64'(0));
    chk("ovf sticky after drain", 64'(overflow_err), 64'(OVF_EXP));

    // Push with pop at full: accepted, no overflow, order preserved.
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    step();
    chk("rst clears overflow", 64'(overflow_err), 64'(0));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 64'h20 + 64'(i), 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 64'hEE, 1'b1);
    step();
    chk("full push+pop overflow", 64'(overflow_err), 64'(0));
    chk("full push+pop yummy", 64'(yummy_out), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full drain%0d valid", i), 64'(valid_out), 64'(1));
      chk($sformatf("full drain%0d data", i), data_out,
          (i == 3) ? 64'hEE : 64'h21 + 64'(i));
      drive(1'b1, 1'b0, 64'h0, 1'b1);
      step();
    end
    chk("full drained empty", 64'(valid_out), 64'(0));

    // Reset in the middle of a packet returns framing to HEAD.
    drive(1'b1, 1'b1, HDR3, 1'b0);   step();
    drive(1'b1, 1'b1, 64'h6, 1'b0);  step();
    drive(1'b1, 1'b1, 64'h7, 1'b0);  step();
    drive(1'b1, 1'b0, 64'h0, 1'b1);  step();
    drive(1'b1, 1'b0, 64'h0, 1'b1);  step();
    drive(1'b1, 1'b0, 64'h0, 1'b0);  step();
    chk("midpkt data", data_out, 64'h7);
    chk("midpkt head", 64'(head_out), 64'(0));
    chk("midpkt tail (rem=2)", 64'(tail_out), 64'(0));
    drive(1'b0, 1'b0, 64'h0, 1'b0);  step();
    chk("midpkt reset valid", 64'(valid_out), 64'(0));
    chk("midpkt reset yummy", 64'(yummy_out), 64'(0));
    drive(1'b1, 1'b1, 64'h44, 1'b0); step();
    chk("post-reset valid", 64'(valid_out), 64'(1));
    chk("post-reset head", 64'(head_out), 64'(1));
    chk("post-reset tail", 64'(tail_out), 64'(1));
    chk("post-reset data", data_out, 64'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
